// File: rtl/modn_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package modn_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 5;

    // Bits needed to hold the values 0 .. v-1.
    function automatic int clog2(input longint v);
        longint x;
        int     r;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/modn_next_calc.sv
// Combinational next-count, wrap and load range evaluation.
// MODN_COUNTER_SAT_EN selects saturating limits instead of modulo wrap.
module modn_next_calc
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_next,
    output logic             step_wrap,
    output logic             at_limit,
    output logic             load_ok
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    always_comb begin
        at_limit  = (mode == DIR_UP) ? (cnt == MAX_VAL) : (cnt == '0);
        load_ok   = ({1'b0, load_val} < MOD_EXT);
        step_wrap = 1'b0;
        cnt_next  = (mode == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
`ifdef MODN_COUNTER_SAT_EN
        if (at_limit) begin
            cnt_next = cnt;
        end
`else
        if (at_limit) begin
            cnt_next  = (mode == DIR_UP) ? '0 : MAX_VAL;
            step_wrap = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with enable, parallel load, terminal count and wrap pulse.
// Build with MODN_COUNTER_SAT_EN for saturating (non-wrapping) behaviour.
module modn_updown_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
        WIDTH < clog2(MODULUS)) begin : g_bad_cfg
        $error("modn_updown_counter: MODULUS must be in 2 .. 2**WIDTH");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] cnt_next;
    logic             step_wrap;
    logic             at_limit;
    logic             load_ok;

    modn_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .cnt       (out_q),
        .mode      (mode),
        .load_val  (load_val),
        .cnt_next  (cnt_next),
        .step_wrap (step_wrap),
        .at_limit  (at_limit),
        .load_ok   (load_ok)
    );

    // Priority: reset > load > en > hold.
    always_comb begin
        out_d      = out_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (reset) begin
            out_d = '0;
        end else if (load) begin
            out_d      = load_ok ? load_val : '0;
            load_err_d = ~load_ok;
        end else if (en) begin
            out_d  = cnt_next;
            wrap_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        out_q      <= out_d;
        wrap_q     <= wrap_d;
        load_err_q <= load_err_d;
    end

    assign out      = out_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = en & ~load & ~reset & at_limit;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares.
module tb_modn_updown_counter;

    localparam int W = 4;
    localparam int M = 5;

    logic         clk;
    logic         reset;
    logic         en;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
    logic         load_err;

    modn_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         tc;
        logic [W-1:0] out;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cnt      = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: counter value as a plain integer in 0 .. M-1.
    task automatic step(input logic r, input logic e, input logic m, input logic l, input int lv);
        exp_t x;
        int   nc;
        bit   w;
        bit   er;
        @(posedge clk);
        #3;
        reset    = r;
        en       = e;
        mode     = m;
        load     = l;
        load_val = W'(lv);
        x.tc = !r && e && !l && ((m == 1'b0 && cnt == M - 1) || (m == 1'b1 && cnt == 0));
        w  = 0;
        er = 0;
        if (r) nc = 0;
        else if (l) begin
            if (lv < M) nc = lv;
            else begin nc = 0; er = 1; end
        end else if (e) begin
`ifdef MODN_COUNTER_SAT_EN
            if (m == 1'b0) nc = (cnt < M - 1) ? cnt + 1 : cnt;
            else           nc = (cnt > 0) ? cnt - 1 : 0;
`else
            if (m == 1'b0) begin nc = (cnt + 1) % M;     w = (cnt == M - 1); end
            else           begin nc = (cnt + M - 1) % M; w = (cnt == 0);     end
`endif
        end else nc = cnt;
        cnt   = nc;
        x.out = W'(nc);
        x.wrap = w;
        x.err  = er;
        q.push_back(x);
    endtask

    // Monitor: tc is checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tc", 32'(tc), 32'(x.tc));
                @(posedge clk);
                #1;
                chk("out", 32'(out), 32'(x.out));
                chk("wrap", 32'(wrap), 32'(x.wrap));
                chk("load_err", 32'(load_err), 32'(x.err));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        load     = 1'b0;
        load_val = '0;

        repeat (3) step(1, 0, 0, 0, 0);
        repeat (12) step(0, 1, 0, 0, 0);
        repeat (6) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 3);
        step(0, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 15);
        step(0, 1, 1, 1, 5);
        step(1, 1, 0, 1, 2);
        step(0, 1, 0, 1, 4);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 3);
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 3);
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 75,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 8,
                 int'($urandom_range(0, 15)));
        end

        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
